// File: rtl/alu16_multiword_seq_pkg.sv
// ---------------------------------------------------------------------------
// Module   : alu16_multiword_seq_pkg
// Brief    : Shared types and 74181 function codes for the multi-word sequencer
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

package alu16_multiword_seq_pkg;

  localparam int ALU_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // 74181 select/mode codes as seen with active-high data
  localparam logic [3:0] SEL_ADD    = 4'b1001;
  localparam logic [3:0] SEL_SUB    = 4'b0110;
  localparam logic [3:0] SEL_XOR    = 4'b0110;
  localparam logic       MODE_ARITH = 1'b0;
  localparam logic       MODE_LOGIC = 1'b1;

endpackage

`default_nettype wire

// File: rtl/alu16_multiword_seq.sv
// ---------------------------------------------------------------------------
// Module   : alu16_multiword_seq
// Brief    : Issues up to WORDS 16-bit slices, LS first, to an external 74181
//            ALU, chaining carries and assembling the wide result.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module alu16_multiword_seq
  import alu16_multiword_seq_pkg::*;
#(
  parameter int WORDS = 4,
  parameter int LW    = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [ALU_W*WORDS-1:0] cmd_a,
  input  logic [ALU_W*WORDS-1:0] cmd_b,
  input  logic [3:0]             cmd_sel,
  input  logic                   cmd_mode,
  input  logic                   cmd_cin,
  input  logic [LW-1:0]          cmd_len,
  output logic [ALU_W-1:0]       alu_a,
  output logic [ALU_W-1:0]       alu_b,
  output logic [3:0]             alu_sel,
  output logic                   alu_mode,
  output logic                   alu_cin,
  input  logic [ALU_W-1:0]       alu_result,
  input  logic                   alu_cout,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [ALU_W*WORDS-1:0] rsp_result,
  output logic                   rsp_cout,
  output logic                   rsp_zero,
  output logic                   busy
);

  localparam int DW = ALU_W * WORDS;
  localparam int SH = $clog2(ALU_W);

  state_e            state_q, state_d;
  logic [LW-1:0]     cnt_q, len_q, len_clamped;
  logic [DW-1:0]     a_q, b_q, res_q;
  logic [3:0]        sel_q;
  logic              mode_q, carry_q, zero_q;
  logic [LW+SH-1:0]  base;

  assign base = {cnt_q, {SH{1'b0}}};

  // Only non-power-of-2 WORDS can receive an out-of-range length
  if ((1 << LW) > WORDS) begin : g_clamp
    localparam logic [LW-1:0] MAX_LEN = LW'(WORDS - 1);
    assign len_clamped = (cmd_len > MAX_LEN) ? MAX_LEN : cmd_len;
  end else begin : g_noclamp
    assign len_clamped = cmd_len;
  end

  always_comb begin
    state_d   = state_q;
    cmd_ready = 1'b0;
    alu_a     = '0;
    alu_b     = '0;
    alu_sel   = '0;
    alu_mode  = 1'b0;
    alu_cin   = 1'b0;
    case (state_q)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_d = RUN;
      end
      RUN: begin
        alu_a    = a_q[base +: ALU_W];
        alu_b    = b_q[base +: ALU_W];
        alu_sel  = sel_q;
        alu_mode = mode_q;
        // carry_q holds cmd_cin for slice 0, then the previous slice's carry
        alu_cin  = carry_q;
        if (cnt_q == len_q) state_d = DONE;
      end
      DONE: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      len_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sel_q   <= '0;
      mode_q  <= 1'b0;
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (cmd_valid) begin
            a_q     <= cmd_a;
            b_q     <= cmd_b;
            sel_q   <= cmd_sel;
            mode_q  <= cmd_mode;
            len_q   <= len_clamped;
            carry_q <= cmd_cin;
            cnt_q   <= '0;
            zero_q  <= 1'b1;
            res_q   <= '0;
          end
        end
        RUN: begin
          res_q[base +: ALU_W] <= alu_result;
          carry_q              <= alu_cout;
          zero_q               <= zero_q & (alu_result == '0);
          cnt_q                <= cnt_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign rsp_valid  = (state_q == DONE);
  assign busy       = (state_q != IDLE);
  assign rsp_result = res_q;
  assign rsp_cout   = carry_q;
  assign rsp_zero   = zero_q;

endmodule

`default_nettype wire

// File: tb/tb_alu16_multiword_seq.sv
// ---------------------------------------------------------------------------
// Module   : tb_alu16_multiword_seq
// Brief    : Directed vector bench; the sequencer drives a behavioural 74181 ALU.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_alu16_multiword_seq;
  import alu16_multiword_seq_pkg::*;

  localparam int WORDS = 4;
  localparam int LW    = 2;
  localparam int DW    = 16 * WORDS;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            cmd_valid, cmd_ready;
  logic [DW-1:0]   cmd_a, cmd_b;
  logic [3:0]      cmd_sel;
  logic            cmd_mode, cmd_cin;
  logic [LW-1:0]   cmd_len;
  logic [15:0]     alu_a, alu_b, alu_result;
  logic [3:0]      alu_sel;
  logic            alu_mode, alu_cin, alu_cout;
  logic            rsp_valid, rsp_ready;
  logic [DW-1:0]   rsp_result;
  logic            rsp_cout, rsp_zero, busy;

  always #5 clk = ~clk;

  alu16_multiword_seq #(.WORDS(WORDS), .LW(LW)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_sel(cmd_sel), .cmd_mode(cmd_mode),
    .cmd_cin(cmd_cin), .cmd_len(cmd_len),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_mode(alu_mode),
    .alu_cin(alu_cin), .alu_result(alu_result), .alu_cout(alu_cout),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_cout(rsp_cout), .rsp_zero(rsp_zero), .busy(busy)
  );

  // Active-high-data 74181 pair/182 behaviour: Cn and Cn+4 are active-low carries
  always_comb begin
    logic [16:0] s;
    logic        c;
    c = ~alu_cin;
    case (alu_sel)
      4'b1001: s = {1'b0, alu_a} + {1'b0, alu_b} + {16'd0, c};
      4'b0110: s = {1'b0, alu_a} + {1'b0, ~alu_b} + {16'd0, c};
      default: s = '0;
    endcase
    alu_cout = ~s[16];
    if (alu_mode) alu_result = (alu_sel == 4'b0110) ? (alu_a ^ alu_b) : 16'h0000;
    else          alu_result = s[15:0];
  end

  typedef struct {
    string         name;
    logic [DW-1:0] a, b;
    logic [3:0]    sel;
    logic          mode, cin;
    logic [LW-1:0] len;
    logic [DW-1:0] exp_res;
    logic          chk_cout, exp_cout, exp_zero;
    logic          chk_cin1, exp_cin1;
    int            hold;
  } vec_t;

  int   n_tests = 0;
  int   n_fail  = 0;
  vec_t vecs[7];
  logic cin_log[8];
  int   edges, runs;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic start_cmd(input vec_t v);
    int guard;
    @(negedge clk);
    cmd_a = v.a; cmd_b = v.b; cmd_sel = v.sel; cmd_mode = v.mode;
    cmd_cin = v.cin; cmd_len = v.len; cmd_valid = 1'b1;
    guard = 0;
    while (!cmd_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    chk({v.name, " cmd_ready"}, {63'd0, cmd_ready}, 64'd1);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  // edges = posedges after the accept edge until rsp_valid is seen
  task automatic collect();
    edges = 0;
    runs  = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (rsp_valid) break;
      if (runs < 8) cin_log[runs] = alu_cin;
      runs++;
      @(posedge clk);
      edges++;
    end
  endtask

  task automatic finish_rsp(input vec_t v);
    for (int i = 0; i < v.hold; i++) begin
      chk({v.name, " hold result"}, rsp_result, v.exp_res);
      chk({v.name, " hold ready"}, {62'd0, cmd_ready, rsp_valid}, 64'd1);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    @(negedge clk);
    chk({v.name, " back to idle"}, {61'd0, busy, rsp_valid, cmd_ready}, 64'd1);
  endtask

  task automatic run_vec(input vec_t v);
    start_cmd(v);
    collect();
    chk({v.name, " latency"}, 64'(edges), 64'(v.len) + 64'd1);
    chk({v.name, " run cycles"}, 64'(runs), 64'(v.len) + 64'd1);
    chk({v.name, " result"}, rsp_result, v.exp_res);
    chk({v.name, " zero"}, {63'd0, rsp_zero}, {63'd0, v.exp_zero});
    chk({v.name, " cin slice0"}, {63'd0, cin_log[0]}, {63'd0, v.cin});
    if (v.chk_cout) chk({v.name, " cout"}, {63'd0, rsp_cout}, {63'd0, v.exp_cout});
    if (v.chk_cin1) chk({v.name, " cin slice1"}, {63'd0, cin_log[1]}, {63'd0, v.exp_cin1});
    finish_rsp(v);
  endtask

  initial begin
    vecs[0] = '{"add_carry1", 64'h0000_0000_0000_FFFF, 64'h1, SEL_ADD, MODE_ARITH, 1'b1, 2'd3,
                64'h0000_0000_0001_0000, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 0};
    vecs[1] = '{"add_allones", 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, SEL_ADD, MODE_ARITH, 1'b1, 2'd3,
                64'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 10};
    vecs[2] = '{"add_wide", 64'h1111_2222_3333_4444, 64'h1111_1111_1111_1111, SEL_ADD, MODE_ARITH,
                1'b1, 2'd3, 64'h2222_3333_4444_5555, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0};
    vecs[3] = '{"add_len1", 64'hFFFF_FFFF_0001_8000, 64'hFFFF_FFFF_0000_8000, SEL_ADD, MODE_ARITH,
                1'b1, 2'd1, 64'h0000_0000_0002_0000, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 0};
    vecs[4] = '{"xor_len1", 64'h1234_5678, 64'h1234_5678, SEL_XOR, MODE_LOGIC, 1'b1, 2'd1,
                64'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0};
    vecs[5] = '{"sub_len0", 64'h0005, 64'h0003, SEL_SUB, MODE_ARITH, 1'b0, 2'd0,
                64'h0002, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0};
    vecs[6] = '{"add_cin0", 64'h0000_FFFF_FFFF, 64'h0, SEL_ADD, MODE_ARITH, 1'b0, 2'd2,
                64'h0001_0000_0000, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 0};

    rst_n = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b0;
    cmd_a = '0; cmd_b = '0; cmd_sel = '0; cmd_mode = 1'b0; cmd_cin = 1'b0; cmd_len = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk("reset outputs", {rsp_result[59:0], rsp_valid, rsp_cout, rsp_zero, busy}, 64'd0);
    chk("reset cmd_ready", {63'd0, cmd_ready}, 64'd1);
    chk("reset alu idle", {28'd0, alu_a, alu_b, alu_sel}, 64'd0);

    foreach (vecs[i]) run_vec(vecs[i]);

    // Reset pulse while slice 2 is on the ALU; the op must vanish without a response
    start_cmd(vecs[2]);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("mid-run slice2 a", {48'd0, alu_a}, 64'h2222);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("midrst outputs", {rsp_result[59:0], rsp_valid, rsp_cout, rsp_zero, busy}, 64'd0);
    chk("midrst result hi", {60'd0, rsp_result[63:60]}, 64'd0);
    chk("midrst cmd_ready", {63'd0, cmd_ready}, 64'd1);
    chk("midrst alu idle", {27'd0, alu_a, alu_b, alu_sel, alu_cin}, 64'd0);
    begin
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < 8; i++) begin
        @(negedge clk);
        seen |= rsp_valid | busy;
      end
      chk("midrst no response", {63'd0, seen}, 64'd0);
    end
    run_vec(vecs[1]);
    run_vec(vecs[0]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
